// File: rtl/clink_capture_ctrl.sv
// clink_capture_ctrl: CC1 trigger, frame wait and line/pixel geometry check for a 3-tap Camera Link X receiver.
// Optional watchdog enabled by defining CLINK_CAPTURE_TIMEOUT_EN.
module clink_capture_ctrl #(
    parameter int TAPS   = 3,
    parameter int LINE_W = 12,
    parameter int PX_W   = 14,
    parameter int TRIG_W = 16,
    parameter int TO_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [TRIG_W-1:0] trig_width,
    input  logic [LINE_W-1:0] exp_lines,
    input  logic [PX_W-1:0]   exp_px,
    input  logic [TO_W-1:0]   timeout_cycles,
    input  logic              fval,
    input  logic              lval,
    input  logic              dval,
    output logic              cc1,
    output logic              busy,
    output logic              image_end,
    output logic              frame_ok,
    output logic [3:0]        err,
    output logic [LINE_W-1:0] lines_seen
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_FV, CAPTURE, DONE} state_t;

    state_t            state, state_n;
    logic              f_q, l_q, d_q, f_q2, l_q2;
    logic              f_rise, f_fall, l_fall, to_hit;
    logic [TRIG_W-1:0] tcnt;
    logic [PX_W-1:0]   px;
    logic [PX_W:0]     px_sum;
    logic [LINE_W-1:0] lines_inc, lines_fin;

    assign cc1  = state == TRIG;
    assign busy = state != IDLE;

`ifdef CLINK_CAPTURE_TIMEOUT_EN
    logic [TO_W-1:0] tocnt;

    // Restarts per WAIT_FV entry and per completed line, so it only catches stalls.
    always_ff @(posedge clk) begin
        if (reset || state == TRIG || (state == CAPTURE && l_fall))
            tocnt <= '0;
        else if (state == WAIT_FV || state == CAPTURE)
            tocnt <= tocnt + TO_W'(1);
    end

    assign to_hit = (state == WAIT_FV || state == CAPTURE) && timeout_cycles != '0 &&
                    tocnt == timeout_cycles - TO_W'(1);
`else
    logic unused_timeout;
    assign unused_timeout = ^timeout_cycles;
    assign to_hit = 1'b0;
`endif

    always_comb begin
        f_rise    = f_q & ~f_q2;
        f_fall    = ~f_q & f_q2;
        l_fall    = ~l_q & l_q2;
        px_sum    = {1'b0, px} + (PX_W+1)'(TAPS);
        lines_inc = &lines_seen ? lines_seen : lines_seen + LINE_W'(1);
        lines_fin = l_fall ? lines_inc : lines_seen;
        state_n   = state;
        if (abort && state != IDLE)
            state_n = IDLE;
        else
            case (state)
                IDLE:    state_n = start ? TRIG : IDLE;
                TRIG:    state_n = tcnt == TRIG_W'(1) ? WAIT_FV : TRIG;
                WAIT_FV: state_n = to_hit ? DONE : f_rise ? CAPTURE : WAIT_FV;
                CAPTURE: state_n = (f_fall || to_hit) ? DONE : CAPTURE;
                default: state_n = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {f_q, l_q, d_q, f_q2, l_q2} <= '0;
            tcnt       <= '0;
            px         <= '0;
            err        <= '0;
            lines_seen <= '0;
            frame_ok   <= 1'b0;
            image_end  <= 1'b0;
        end else begin
            {f_q, l_q, d_q, f_q2, l_q2} <= {fval, lval, dval, f_q, l_q};
            image_end <= 1'b0;
            if (abort && state != IDLE) begin
                err[2]   <= 1'b1;
                frame_ok <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        err        <= '0;
                        lines_seen <= '0;
                        px         <= '0;
                        frame_ok   <= 1'b0;
                        tcnt       <= trig_width == '0 ? TRIG_W'(1) : trig_width;
                    end
                    TRIG: tcnt <= tcnt - TRIG_W'(1);
                    CAPTURE: begin
                        px <= l_fall ? '0 : (f_q & l_q & d_q) ? (px_sum[PX_W] ? '1 : px_sum[PX_W-1:0]) : px;
                        if (l_fall) begin
                            err[0]     <= err[0] | (px != exp_px);
                            lines_seen <= lines_inc;
                        end
                        if (f_fall || to_hit)
                            err[1] <= err[1] | (lines_fin != exp_lines);
                    end
                    DONE: begin
                        image_end <= 1'b1;
                        frame_ok  <= ~|err;
                    end
                    default: ;
                endcase
                if (to_hit)
                    err[3] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clink_capture_ctrl.sv
// tb_clink_capture_ctrl: directed frames against a timing/geometry model of the capture sequencer.
module tb_clink_capture_ctrl;
    localparam int LW = 12, PW = 14, TW = 16, OW = 32;
    localparam int NEVER = 1 << 30;

    logic          clk = 0, reset = 1, start = 0, abort = 0, fval = 0, lval = 0, dval = 0;
    logic [TW-1:0] trig_width = 4;
    logic [LW-1:0] exp_lines = 4;
    logic [PW-1:0] exp_px = 9;
    logic [OW-1:0] timeout_cycles = 0;
    logic          cc1, busy, image_end, frame_ok;
    logic [3:0]    err;
    logic [LW-1:0] lines_seen;

    int tests = 0, fails = 0, cyc = 0, ie_cnt = 0, c0 = 0, n = 0;
    int cc1_lo = 0, cc1_hi = 0, busy_lo = 0, busy_hi = 0, ie_at = -1, chk_at = -1;
    logic [3:0] m_err = 0;
    logic       m_ok = 0;
    int         m_lines = 0;
    int         dv[8];

    clink_capture_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .trig_width(trig_width),
        .exp_lines(exp_lines), .exp_px(exp_px), .timeout_cycles(timeout_cycles),
        .fval(fval), .lval(lval), .dval(dval), .cc1(cc1), .busy(busy), .image_end(image_end),
        .frame_ok(frame_ok), .err(err), .lines_seen(lines_seen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Per-cycle comparison against the expected windows and end-of-frame status
    always @(negedge clk) begin
        chk("cc1", int'(cc1), int'(cyc >= cc1_lo && cyc < cc1_hi));
        chk("busy", int'(busy), int'(cyc >= busy_lo && cyc < busy_hi));
        chk("image_end", int'(image_end), int'(cyc == ie_at));
        if (image_end) ie_cnt++;
        if (cyc == chk_at) begin
            chk("err", int'(err), int'(m_err));
            chk("frame_ok", int'(frame_ok), int'(m_ok));
            chk("lines_seen", int'(lines_seen), m_lines);
        end
    end

    task automatic tick(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(input int tw);
        trig_width = TW'(tw);
        cc1_lo  = cyc + 1;
        cc1_hi  = cyc + 1 + (tw == 0 ? 1 : tw);
        busy_lo = cyc + 1;
        busy_hi = NEVER;
        ie_at   = -1;
        chk_at  = -1;
        start = 1;
        tick(1);
        start = 0;
    endtask

    // nl lines with dv[i] data cycles each; tog closes the last line together with fval
    task automatic frame(input int nl, input bit tog, input bit ms, input bit cap);
        logic [3:0] e;
        fval = 1;
        tick(2);
        for (int i = 0; i < nl; i++) begin
            lval = 1;
            dval = 1;
            if (ms && i == 0) begin
                start = 1;
                tick(1);
                start = 0;
                tick(dv[i] - 1);
            end else
                tick(dv[i]);
            dval = 0;
            if (!(tog && i == nl - 1)) begin
                lval = 0;
                tick(2);
            end
        end
        if (cap) begin
            e = 0;
            for (int i = 0; i < nl; i++)
                if (3 * dv[i] != int'(exp_px)) e[0] = 1;
            e[1] = nl != int'(exp_lines);
            m_err = e;
            m_ok = e == 0;
            m_lines = nl;
            ie_at = cyc + 3;
            chk_at = cyc + 3;
            busy_hi = cyc + 3;
        end
        lval = 0;
        fval = 0;
        tick(5);
    endtask

    initial begin
        dv = '{3, 3, 3, 3, 3, 3, 3, 3};
        tick(3);
        chk("reset busy", int'(busy), 0);
        chk("reset cc1", int'(cc1), 0);
        chk("reset err", int'(err), 0);
        chk("reset lines", int'(lines_seen), 0);
        reset = 0;
        tick(2);

        do_start(4);
        chk("t1 cc1 first", int'(cc1), 1);
        chk("t1 busy", int'(busy), 1);
        tick(6);
        c0 = ie_cnt;
        frame(4, 0, 0, 1);
        chk("t2 err", int'(err), 0);
        chk("t2 frame_ok", int'(frame_ok), 1);
        chk("t2 lines", int'(lines_seen), 4);
        chk("t2 image_end count", ie_cnt, c0 + 1);

        dv[1] = 4;
        do_start(2);
        tick(4);
        frame(4, 0, 0, 1);
        chk("t3 px err", int'(err), 1);
        chk("t3 frame_ok", int'(frame_ok), 0);
        dv[1] = 3;
        do_start(2);
        tick(4);
        frame(5, 0, 0, 1);
        chk("t3 line err", int'(err), 2);
        chk("t3 lines", int'(lines_seen), 5);

        fval = 1;
        tick(2);
        do_start(3);
        tick(6);
        fval = 0;
        tick(3);
        c0 = ie_cnt;
        frame(4, 0, 1, 1);
        chk("t4 err", int'(err), 0);
        chk("t4 image_end count", ie_cnt, c0 + 1);

        do_start(2);
        tick(4);
        fval = 1;
        tick(3);
        lval = 1;
        dval = 1;
        tick(2);
        abort = 1;
        busy_hi = cyc + 1;
        chk_at = cyc + 1;
        m_err = 4'b0100;
        m_ok = 0;
        m_lines = 0;
        c0 = ie_cnt;
        tick(1);
        abort = 0;
        chk("t5 busy after abort", int'(busy), 0);
        tick(2);
        lval = 0;
        dval = 0;
        fval = 0;
        tick(5);
        chk("t5 err", int'(err), 4);
        chk("t5 no image_end", ie_cnt, c0);
        chk_at = cyc + 2;
        abort = 1;
        tick(1);
        abort = 0;
        tick(2);
        chk("t5 idle abort err", int'(err), 4);
        do_start(1);
        tick(3);
        frame(4, 1, 0, 1);
        chk("t5 restart err", int'(err), 0);
        chk("t5 restart ok", int'(frame_ok), 1);

        do_start(0);
        tick(2);
        fval = 1;
        tick(2);
        lval = 1;
        dval = 1;
        tick(3);
        reset = 1;
        busy_hi = cyc + 1;
        chk_at = cyc + 1;
        m_err = 0;
        m_ok = 0;
        m_lines = 0;
        c0 = ie_cnt;
        tick(2);
        reset = 0;
        lval = 0;
        dval = 0;
        fval = 0;
        tick(5);
        chk("reset mid no image_end", ie_cnt, c0);

`ifdef CLINK_CAPTURE_TIMEOUT_EN
        timeout_cycles = 100;
        n = cyc;
        do_start(4);
        ie_at = n + 106;
        chk_at = ie_at;
        busy_hi = ie_at;
        m_err = 4'b1000;
        m_ok = 0;
        m_lines = 0;
        tick(115);
        chk("t6 timeout err", int'(err), 8);
        timeout_cycles = 0;
`else
        timeout_cycles = 100;
        do_start(4);
        tick(150);
        chk("t6 still busy", int'(busy), 1);
        abort = 1;
        busy_hi = cyc + 1;
        chk_at = cyc + 1;
        m_err = 4'b0100;
        m_ok = 0;
        m_lines = 0;
        tick(1);
        abort = 0;
        tick(3);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
